// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register target.
package spi_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR,
        RD
    } tgt_state_t;

    localparam int unsigned CMD_RW_BIT = 7;
    localparam int unsigned BYTE_BITS  = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect stage; emits one-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_reg_target.sv
// SPI target with an auto-incrementing 8-bit register bank and write strobe.
// Optional aborted-frame counter enabled by defining SPI_TARGET_ERRCNT_EN.
module spi_reg_target
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    input  logic [1:0]            mode,
    output logic                  miso,
    output logic                  busy,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            wr_data,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic [7:0]            err_cnt
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [1:0] mosi_sync;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .din(cs), .rise(cs_rise), .fall(cs_fall)
    );

    // mosi only needs the synchronizer so it lines up with the sclk edge pulses
    always_ff @(posedge clk) begin
        if (!reset) mosi_sync <= '0;
        else        mosi_sync <= {mosi_sync[0], mosi};
    end

    tgt_state_t             state;
    spi_mode_t              mode_q;
    logic [2:0]             bit_cnt;
    logic [BYTE_BITS-2:0]   rx_sr;
    logic [BYTE_BITS-1:0]   tx_sr;
    logic [ADDR_W-1:0]      addr;
    logic [7:0]             regs [NUM_REGS];

    logic                   lead_ev, trail_ev, sample_ev, shift_ev, byte_done;
    logic [BYTE_BITS-1:0]   rx_byte;
    logic [ADDR_W-1:0]      addr_inc;

    assign lead_ev   = mode_q.cpol ? sclk_fall : sclk_rise;
    assign trail_ev  = mode_q.cpol ? sclk_rise : sclk_fall;
    assign sample_ev = (state != IDLE) && (mode_q.cpha ? trail_ev : lead_ev);
    assign shift_ev  = (state != IDLE) && (mode_q.cpha ? lead_ev : trail_ev);
    assign byte_done = sample_ev && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr, mosi_sync[1]};
    assign addr_inc  = addr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            mode_q    <= '0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            addr      <= '0;
            miso      <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            // commit lags the strobe register by one clk, so a same-cycle preload sees the old value
            if (wr_strobe) regs[wr_addr] <= wr_data;

            if (cs_fall) begin
                mode_q  <= spi_mode_t'(mode);
                bit_cnt <= '0;
                state   <= CMD;
                busy    <= 1'b1;
                miso    <= 1'b0;
            end else if (state != IDLE) begin
                if (sample_ev) begin
                    rx_sr   <= rx_byte[BYTE_BITS-2:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        CMD: begin
                            addr <= rx_byte[ADDR_W-1:0];
                            if (rx_byte[CMD_RW_BIT]) begin
                                state <= RD;
                                tx_sr <= regs[rx_byte[ADDR_W-1:0]];
                            end else begin
                                state <= WR;
                            end
                        end
                        WR: begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                            wr_data   <= rx_byte;
                            addr      <= addr_inc;
                        end
                        RD: begin
                            addr  <= addr_inc;
                            tx_sr <= regs[addr_inc];
                        end
                        default: ;
                    endcase
                end
                if (shift_ev) begin
                    if (state == RD) begin
                        miso  <= tx_sr[BYTE_BITS-1];
                        tx_sr <= {tx_sr[BYTE_BITS-2:0], 1'b0};
                    end else begin
                        miso <= 1'b0;
                    end
                end
                // placed last so a coincident final sample still completes its byte first
                if (cs_rise) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    miso  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs[i];
    end

`ifdef SPI_TARGET_ERRCNT_EN
    logic [2:0] cnt_eff;
    logic       cmd_open, abort;
    logic [7:0] err_q;

    assign cnt_eff  = sample_ev ? bit_cnt + 3'd1 : bit_cnt;
    assign cmd_open = (state == CMD) && !byte_done;
    assign abort    = cs_rise && !cs_fall && (state != IDLE) && ((cnt_eff != 3'd0) || cmd_open);

    always_ff @(posedge clk) begin
        if (!reset)                       err_q <= '0;
        else if (abort && (err_q != '1)) err_q <= err_q + 8'd1;
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench for spi_reg_target: a behavioural SPI master drives frames in all four modes.
module tb_spi_reg_target;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned ADDR_W   = 4;
`ifdef SPI_TARGET_ERRCNT_EN
    localparam logic [7:0] ERR_EXP = 8'd1;
`else
    localparam logic [7:0] ERR_EXP = 8'd0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  sclk = 1'b0;
    logic                  cs = 1'b1;
    logic                  mosi = 1'b0;
    logic [1:0]            mode = 2'b00;
    logic                  miso, busy, wr_strobe;
    logic [ADDR_W-1:0]     wr_addr;
    logic [7:0]            wr_data, err_cnt;
    logic [NUM_REGS*8-1:0] regs_flat;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int miso_cmd_hi = 0;
    logic in_cmd = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always #5 clk = ~clk;

    spi_reg_target #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .mode(mode),
        .miso(miso), .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .regs_flat(regs_flat), .err_cnt(err_cnt)
    );

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobes   <= strobes + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
        if (in_cmd && (miso !== 1'b0)) miso_cmd_hi <= miso_cmd_hi + 1;
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic xfer_byte(input logic [1:0] m, input logic [7:0] tx, input int nbits,
                             output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!m[0]) begin
                mosi = tx[7-i];
                half();
                sclk = ~m[1];
                rx[7-i] = miso;
                half();
                sclk = m[1];
            end else begin
                sclk = ~m[1];
                mosi = tx[7-i];
                half();
                sclk = m[1];
                rx[7-i] = miso;
                half();
            end
        end
    endtask

    task automatic spi_frame(input logic [1:0] m, input int nb, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input int last_bits,
                             output logic [7:0] r0, output logic [7:0] r1, output logic [7:0] r2);
        logic [7:0] tx, rx;
        r0 = '0; r1 = '0; r2 = '0;
        mode = m;
        sclk = m[1];
        mosi = 1'b0;
        half();
        cs = 1'b0;
        in_cmd = 1'b1;
        half();
        for (int k = 0; k < nb; k++) begin
            tx = (k == 0) ? b0 : (k == 1) ? b1 : b2;
            xfer_byte(m, tx, (k == nb - 1) ? last_bits : 8, rx);
            if (k == 0) in_cmd = 1'b0;
            if (k == 0) r0 = rx;
            else if (k == 1) r1 = rx;
            else r2 = rx;
        end
        half();
        cs = 1'b1;
        half();
        half();
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %0h expected 0", miso); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0h expected 0", wr_strobe); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0h expected 0", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %0h expected 0", wr_data); end
        checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs: got %0h expected 0", regs_flat); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %0h expected 0", err_cnt); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] r0, r1, r2;
        int s0;
        s0 = strobes;
        spi_frame(2'b10, 2, 8'h03, 8'hBD, 8'h00, 8, r0, r1, r2);
        checks++; if (strobes - s0 != 1) begin errors++; $display("FAIL write_strobes: got %0d expected 1", strobes - s0); end
        checks++; if (last_addr !== 4'd3) begin errors++; $display("FAIL write_addr: got %0h expected 3", last_addr); end
        checks++; if (last_data !== 8'hBD) begin errors++; $display("FAIL write_data: got %0h expected bd", last_data); end
        checks++; if (regs_flat[31:24] !== 8'hBD) begin errors++; $display("FAIL write_reg3: got %0h expected bd", regs_flat[31:24]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_idle: got %0h expected 0", busy); end
    endtask

    task automatic test_read(input logic [1:0] m, input string tag);
        logic [7:0] r0, r1, r2;
        int s0, h0;
        s0 = strobes;
        h0 = miso_cmd_hi;
        spi_frame(m, 2, 8'h83, 8'h00, 8'h00, 8, r0, r1, r2);
        checks++; if (r1 !== 8'hBD) begin errors++; $display("FAIL %s_data: got %0h expected bd", tag, r1); end
        checks++; if (r0 !== 8'h00) begin errors++; $display("FAIL %s_cmd_rx: got %0h expected 0", tag, r0); end
        checks++; if (miso_cmd_hi != h0) begin errors++; $display("FAIL %s_miso_cmd: got %0d high samples expected 0", tag, miso_cmd_hi - h0); end
        checks++; if (strobes != s0) begin errors++; $display("FAIL %s_no_write: got %0d strobes expected 0", tag, strobes - s0); end
    endtask

    task automatic test_burst_write();
        logic [7:0] r0, r1, r2;
        int s0;
        s0 = strobes;
        spi_frame(2'b11, 3, 8'h0F, 8'h11, 8'h22, 8, r0, r1, r2);
        checks++; if (strobes - s0 != 2) begin errors++; $display("FAIL burst_strobes: got %0d expected 2", strobes - s0); end
        checks++; if (regs_flat[127:120] !== 8'h11) begin errors++; $display("FAIL burst_reg15: got %0h expected 11", regs_flat[127:120]); end
        checks++; if (regs_flat[7:0] !== 8'h22) begin errors++; $display("FAIL burst_reg0_wrap: got %0h expected 22", regs_flat[7:0]); end
        checks++; if (last_addr !== 4'd0) begin errors++; $display("FAIL burst_last_addr: got %0h expected 0", last_addr); end
    endtask

    task automatic test_burst_read();
        logic [7:0] r0, r1, r2;
        int s0;
        s0 = strobes;
        spi_frame(2'b10, 3, 8'h8F, 8'hFF, 8'hFF, 8, r0, r1, r2);
        checks++; if (r1 !== 8'h11) begin errors++; $display("FAIL bread_byte1: got %0h expected 11", r1); end
        checks++; if (r2 !== 8'h22) begin errors++; $display("FAIL bread_byte2_wrap: got %0h expected 22", r2); end
        checks++; if (strobes != s0) begin errors++; $display("FAIL bread_mosi_ignored: got %0d strobes expected 0", strobes - s0); end
        checks++; if (regs_flat[7:0] !== 8'h22) begin errors++; $display("FAIL bread_reg0_kept: got %0h expected 22", regs_flat[7:0]); end
    endtask

    task automatic test_abort();
        logic [7:0] r0, r1, r2;
        int s0;
        s0 = strobes;
        spi_frame(2'b01, 2, 8'h05, 8'hA0, 8'h00, 4, r0, r1, r2);
        checks++; if (strobes != s0) begin errors++; $display("FAIL abort_no_write: got %0d strobes expected 0", strobes - s0); end
        checks++; if (regs_flat[47:40] !== 8'h00) begin errors++; $display("FAIL abort_reg5: got %0h expected 0", regs_flat[47:40]); end
        checks++; if (err_cnt !== ERR_EXP) begin errors++; $display("FAIL abort_err_cnt: got %0h expected %0h", err_cnt, ERR_EXP); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0h expected 0", busy); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx, r0, r1, r2;
        mode = 2'b00;
        sclk = 1'b0;
        half();
        cs = 1'b0;
        half();
        xfer_byte(2'b00, 8'h83, 8, rx);
        xfer_byte(2'b00, 8'h00, 4, rx);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midread_busy: got %0h expected 1", busy); end
        reset = 1'b0;
        cs = 1'b1;
        @(negedge clk);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL midreset_miso: got %0h expected 0", miso); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0h expected 0", busy); end
        checks++; if (regs_flat !== '0) begin errors++; $display("FAIL midreset_regs: got %0h expected 0", regs_flat); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL midreset_err_cnt: got %0h expected 0", err_cnt); end
        reset = 1'b1;
        half();
        spi_frame(2'b00, 2, 8'h83, 8'h00, 8'h00, 8, r0, r1, r2);
        checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL postreset_read: got %0h expected 0", r1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(2'b00, "read_m0");
        test_read(2'b01, "read_m1");
        test_burst_write();
        test_burst_read();
        test_abort();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
